// File: rtl/layer_mvm_ctrl_pkg.sv
// Shared types and width helpers for the matrix-vector layer sequencer.
// LAT is 1 cycle (sync ROM/RAM read), 2 when PIPE_MUL_EN adds a multiplier register.
// No flow control lives here; consumers handle valid/ready.
package mvm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        DRAIN,
        WB,
        DONE
    } state_t;

`ifdef PIPE_MUL_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    function automatic int clog2_min1(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

    // Counter wide enough to hold 0..n inclusive.
    function automatic int cnt_w(input int n);
        return clog2_min1(n + 1);
    endfunction

    function automatic int waddr_w(input int m, input int n);
        return clog2_min1(m * n);
    endfunction

endpackage

// File: rtl/layer_mvm_ctrl_if.sv
// Control/handshake bundle between the layer sequencer and its datapath.
// Purely wires, no latency.
// s_valid/s_ready on the x stream, m_valid/m_ready on the y stream.
interface layer_mvm_ctrl_if #(
    parameter int M = 3,
    parameter int N = 3
);
    localparam int LOGN = mvm_pkg::cnt_w(N);
    localparam int LOGM = mvm_pkg::cnt_w(M);
    localparam int LOGW = mvm_pkg::waddr_w(M, N);

    logic            s_valid;
    logic            s_ready;
    logic            m_ready;
    logic            m_valid;
    logic            wr_en_x;
    logic [LOGN-1:0] addr_x;
    logic [LOGW-1:0] addr_w;
    logic [LOGM-1:0] addr_b;
    logic            clear_acc;
    logic            acc_en;
    logic            out_load;
    logic            busy;

    modport master (
        input  s_valid, m_ready,
        output s_ready, m_valid, wr_en_x, addr_x, addr_w, addr_b,
               clear_acc, acc_en, out_load, busy
    );

    modport slave (
        output s_valid, m_ready,
        input  s_ready, m_valid, wr_en_x, addr_x, addr_w, addr_b,
               clear_acc, acc_en, out_load, busy
    );

endinterface

// File: rtl/layer_mvm_ctrl_strobe_dly.sv
// Delays issue-time first/next flags into clear_acc/acc_en strobes.
// Latency LAT cycles; no backpressure, the sequencer never stalls mid-row.
module mvm_strobe_dly #(
    parameter int LAT = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_first,
    input  logic i_next,
    output logic o_clear_acc,
    output logic o_acc_en
);

    logic [LAT-1:0] r_first;
    logic [LAT-1:0] r_next;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_first <= '0;
            r_next  <= '0;
        end else begin
            r_first[0] <= i_first;
            r_next[0]  <= i_next;
            for (int i = 1; i < LAT; i++) begin
                r_first[i] <= r_first[i-1];
                r_next[i]  <= r_next[i-1];
            end
        end
    end

    assign o_clear_acc = r_first[LAT-1];
    assign o_acc_en    = r_next[LAT-1];

endmodule

// File: rtl/layer_mvm_ctrl.sv
// Sequencer for y = W*x + b: loads N x words, walks W row by row, hands rows to the out reg.
// Row period N+LAT+1 (LAT=2 with PIPE_MUL_EN defined); strobes LAT cycles after issue.
// x accepted only in IDLE/LOAD; WB stalls while the output slot is full and m_ready is low.
module layer_mvm_ctrl
    import mvm_pkg::*;
#(
    parameter int M = 3,
    parameter int N = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    layer_mvm_ctrl_if.master  bus
);

    localparam int LOGN = cnt_w(N);
    localparam int LOGM = cnt_w(M);
    localparam int LOGW = waddr_w(M, N);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_run;
    logic [LOGN-1:0] r_col;
    logic [LOGN-1:0] w_col_nxt;
    logic [LOGM-1:0] r_row;
    logic [LOGM-1:0] w_row_nxt;
    logic [1:0]      r_drn;
    logic [1:0]      w_drn_nxt;
    logic            r_m_valid;
    logic            w_m_valid_nxt;
    logic            w_s_ready;
    logic            w_s_hs;
    logic            w_m_hs;
    logic            w_fire;
    logic            w_first;
    logic            w_next;

    // r_run keeps s_ready low until the first clock after reset release.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= IDLE;
            r_run     <= 1'b0;
            r_col     <= '0;
            r_row     <= '0;
            r_drn     <= '0;
            r_m_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_run     <= 1'b1;
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
            r_drn     <= w_drn_nxt;
            r_m_valid <= w_m_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_drn_nxt   = r_drn;
        w_fire      = 1'b0;
        w_first     = 1'b0;
        w_next      = 1'b0;
        w_s_ready   = r_run && ((r_state == IDLE) || (r_state == LOAD));
        w_s_hs      = w_s_ready && bus.s_valid;
        w_m_hs      = r_m_valid && bus.m_ready;

        case (r_state)
            IDLE: begin
                if (w_s_hs) begin
                    if (N == 1) begin
                        w_state_nxt = ISSUE;
                    end else begin
                        w_state_nxt = LOAD;
                        w_col_nxt   = r_col + LOGN'(1);
                    end
                end
            end
            LOAD: begin
                if (w_s_hs) begin
                    if (r_col == LOGN'(N - 1)) begin
                        w_col_nxt   = '0;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_col_nxt = r_col + LOGN'(1);
                    end
                end
            end
            ISSUE: begin
                w_first = (r_col == '0);
                w_next  = (r_col != '0);
                if (r_col == LOGN'(N - 1)) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_col_nxt = r_col + LOGN'(1);
                end
            end
            DRAIN: begin
                if (r_drn == 2'(LAT - 1)) begin
                    w_drn_nxt   = '0;
                    w_state_nxt = WB;
                end else begin
                    w_drn_nxt = r_drn + 2'd1;
                end
            end
            WB: begin
                // Column stays at N-1 while waiting so the addresses hold.
                if (!r_m_valid || bus.m_ready) begin
                    w_fire      = 1'b1;
                    w_col_nxt   = '0;
                    w_row_nxt   = r_row + LOGM'(1);
                    w_state_nxt = (r_row == LOGM'(M - 1)) ? DONE : ISSUE;
                end
            end
            DONE: begin
                if (w_m_hs) begin
                    w_state_nxt = IDLE;
                    w_row_nxt   = '0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_m_valid_nxt = r_m_valid;
        if (w_fire) begin
            w_m_valid_nxt = 1'b1;
        end else if (w_m_hs) begin
            w_m_valid_nxt = 1'b0;
        end
    end

    mvm_strobe_dly #(.LAT(LAT)) u_strobe_dly (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_first     (w_first),
        .i_next      (w_next),
        .o_clear_acc (bus.clear_acc),
        .o_acc_en    (bus.acc_en)
    );

    assign bus.s_ready  = w_s_ready;
    assign bus.wr_en_x  = w_s_hs;
    assign bus.addr_x   = r_col;
    assign bus.addr_w   = LOGW'(int'(r_row) * N + int'(r_col));
    assign bus.addr_b   = r_row;
    assign bus.out_load = w_fire;
    assign bus.m_valid  = r_m_valid;
    assign bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_layer_mvm_ctrl.sv
// Directed bench for layer_mvm_ctrl (M=3, N=3); cycle 0 is the first x handshake.
module tb_layer_mvm_ctrl;

    localparam int M = 3;
    localparam int N = 3;
`ifdef PIPE_MUL_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int P  = N + LAT + 1;
    localparam int NC = 48;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    layer_mvm_ctrl_if #(.M(M), .N(N)) bus();

    layer_mvm_ctrl #(.M(M), .N(N)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [14:0] outs_vec;
    assign outs_vec = {bus.s_ready, bus.wr_en_x, bus.m_valid, bus.busy, bus.clear_acc,
                       bus.acc_en, bus.out_load, bus.addr_x, bus.addr_w, bus.addr_b};

    logic rec_srdy [NC];
    logic rec_wr   [NC];
    logic rec_clr  [NC];
    logic rec_acc  [NC];
    logic rec_ol   [NC];
    logic rec_mv   [NC];
    logic rec_busy [NC];
    logic rec_hs   [NC];
    int   rec_ax   [NC];
    int   rec_aw   [NC];
    int   rec_ab   [NC];

    // Called #1 after a posedge; drives per-cycle inputs, samples at the negedge.
    task automatic run(input int n, input logic [NC-1:0] sv, input logic [NC-1:0] mr);
        for (int c = 0; c < n; c++) begin
            bus.s_valid = sv[c];
            bus.m_ready = mr[c];
            @(negedge clk);
            rec_srdy[c] = bus.s_ready;
            rec_wr[c]   = bus.wr_en_x;
            rec_clr[c]  = bus.clear_acc;
            rec_acc[c]  = bus.acc_en;
            rec_ol[c]   = bus.out_load;
            rec_mv[c]   = bus.m_valid;
            rec_busy[c] = bus.busy;
            rec_hs[c]   = bus.m_valid & bus.m_ready;
            rec_ax[c]   = int'(bus.addr_x);
            rec_aw[c]   = int'(bus.addr_w);
            rec_ab[c]   = int'(bus.addr_b);
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (outs_vec !== 15'd0) begin
            failures++;
            $display("FAIL reset_outs: got %b expected all zero", outs_vec);
        end
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_s_ready: got %b expected 1", bus.s_ready);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_nominal();
        int n_clr;
        int n_ol;
        int n_hs;
        int last;
        run(30, 48'h7, '1);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (rec_wr[i] !== 1'b1 || rec_ax[i] !== i) begin
                failures++;
                $display("FAIL nom_load c%0d: wr=%b addr_x=%0d expected wr=1 addr_x=%0d", i, rec_wr[i], rec_ax[i], i);
            end
        end
        checks++;
        if (rec_wr[N] !== 1'b0 || rec_srdy[N] !== 1'b0) begin
            failures++;
            $display("FAIL nom_sready_off: wr=%b s_ready=%b expected 0/0", rec_wr[N], rec_srdy[N]);
        end
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                checks++;
                if (rec_aw[3 + r*P + c] !== r*N + c || rec_ab[3 + r*P + c] !== r ||
                    rec_ax[3 + r*P + c] !== c) begin
                    failures++;
                    $display("FAIL nom_issue r%0d c%0d: aw=%0d ab=%0d ax=%0d expected %0d/%0d/%0d",
                             r, c, rec_aw[3 + r*P + c], rec_ab[3 + r*P + c], rec_ax[3 + r*P + c],
                             r*N + c, r, c);
                end
            end
            checks++;
            if (rec_clr[3 + r*P + LAT] !== 1'b1) begin
                failures++;
                $display("FAIL nom_clear r%0d: got %b expected 1", r, rec_clr[3 + r*P + LAT]);
            end
            for (int c = 1; c < N; c++) begin
                checks++;
                if (rec_acc[3 + r*P + c + LAT] !== 1'b1) begin
                    failures++;
                    $display("FAIL nom_acc_en r%0d c%0d: got %b expected 1", r, c, rec_acc[3 + r*P + c + LAT]);
                end
            end
            checks++;
            if (rec_ol[3 + r*P + N + LAT] !== 1'b1 || rec_mv[3 + r*P + N + LAT + 1] !== 1'b1) begin
                failures++;
                $display("FAIL nom_out_load r%0d: ol=%b mv_next=%b expected 1/1",
                         r, rec_ol[3 + r*P + N + LAT], rec_mv[3 + r*P + N + LAT + 1]);
            end
        end
        n_clr = 0;
        n_ol  = 0;
        n_hs  = 0;
        for (int c = 0; c < 30; c++) begin
            if (rec_clr[c] === 1'b1) n_clr++;
            if (rec_ol[c] === 1'b1) n_ol++;
            if (rec_hs[c] === 1'b1) n_hs++;
            checks++;
            if (rec_clr[c] === 1'b1 && rec_acc[c] === 1'b1) begin
                failures++;
                $display("FAIL nom_strobe_excl cycle %0d: clear_acc and acc_en both 1", c);
            end
        end
        checks++;
        if (n_clr !== M || n_ol !== M || n_hs !== M) begin
            failures++;
            $display("FAIL nom_counts: clear=%0d out_load=%0d hs=%0d expected %0d each", n_clr, n_ol, n_hs, M);
        end
        last = 3 + (M-1)*P + N + LAT;
        checks++;
        if (rec_busy[last+1] !== 1'b1 || rec_hs[last+1] !== 1'b1 ||
            rec_busy[last+2] !== 1'b0 || rec_srdy[last+2] !== 1'b1) begin
            failures++;
            $display("FAIL nom_done: busy=%b hs=%b then busy=%b s_ready=%b expected 1/1 then 0/1",
                     rec_busy[last+1], rec_hs[last+1], rec_busy[last+2], rec_srdy[last+2]);
        end
    endtask

    task automatic test_row_period();
        run(30, 48'h7, '1);
`ifdef PIPE_MUL_EN
        checks++;
        if (rec_clr[5] !== 1'b1 || rec_clr[4] !== 1'b0) begin
            failures++;
            $display("FAIL pipe_clear: c4=%b c5=%b expected 0/1", rec_clr[4], rec_clr[5]);
        end
        checks++;
        if (rec_ol[8] !== 1'b1 || rec_ol[14] !== 1'b1 || rec_ol[20] !== 1'b1 || rec_ol[7] !== 1'b0) begin
            failures++;
            $display("FAIL pipe_period: ol7=%b ol8=%b ol14=%b ol20=%b expected 0/1/1/1",
                     rec_ol[7], rec_ol[8], rec_ol[14], rec_ol[20]);
        end
`else
        checks++;
        if (rec_clr[4] !== 1'b1 || rec_clr[3] !== 1'b0) begin
            failures++;
            $display("FAIL period_clear: c3=%b c4=%b expected 0/1", rec_clr[3], rec_clr[4]);
        end
        checks++;
        if (rec_ol[7] !== 1'b1 || rec_ol[12] !== 1'b1 || rec_ol[17] !== 1'b1 || rec_ol[8] !== 1'b0) begin
            failures++;
            $display("FAIL period_out_load: ol7=%b ol8=%b ol12=%b ol17=%b expected 1/0/1/1",
                     rec_ol[7], rec_ol[8], rec_ol[12], rec_ol[17]);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [NC-1:0] mr;
        int n_hs;
        int n_ol_wait;
        mr = '1;
        for (int c = 8; c <= 19; c++) mr[c] = 1'b0;
        run(36, 48'h7, mr);
        n_ol_wait = 0;
        for (int c = 3 + N + LAT + 1; c < 20; c++) begin
            if (rec_ol[c] === 1'b1) n_ol_wait++;
        end
        checks++;
        if (n_ol_wait !== 0) begin
            failures++;
            $display("FAIL bp_no_load_wait: got %0d out_load pulses expected 0", n_ol_wait);
        end
        checks++;
        if (rec_ol[20] !== 1'b1 || rec_mv[20] !== 1'b1) begin
            failures++;
            $display("FAIL bp_load_c20: ol=%b mv=%b expected 1/1", rec_ol[20], rec_mv[20]);
        end
        checks++;
        if (rec_acc[19] !== 1'b0 || rec_aw[19] !== 2*N - 1 || rec_mv[19] !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold: acc_en=%b aw=%0d mv=%b expected 0/%0d/1", rec_acc[19], rec_aw[19], rec_mv[19], 2*N - 1);
        end
        n_hs = 0;
        for (int c = 0; c < 36; c++) begin
            if (rec_hs[c] === 1'b1) n_hs++;
        end
        checks++;
        if (n_hs !== M || rec_busy[35] !== 1'b0) begin
            failures++;
            $display("FAIL bp_handshakes: got %0d busy_end=%b expected %0d busy_end=0", n_hs, rec_busy[35], M);
        end
    endtask

    task automatic test_s_gaps();
        int n_wr;
        run(36, 48'h19, '1);
        n_wr = 0;
        for (int c = 0; c < 36; c++) begin
            if (rec_wr[c] === 1'b1) n_wr++;
        end
        checks++;
        if (n_wr !== N) begin
            failures++;
            $display("FAIL gap_wr_count: got %0d expected %0d", n_wr, N);
        end
        checks++;
        if (rec_wr[0] !== 1'b1 || rec_ax[0] !== 0 || rec_wr[3] !== 1'b1 || rec_ax[3] !== 1 ||
            rec_wr[4] !== 1'b1 || rec_ax[4] !== 2) begin
            failures++;
            $display("FAIL gap_wr_addr: ax0=%0d ax3=%0d ax4=%0d expected 0/1/2", rec_ax[0], rec_ax[3], rec_ax[4]);
        end
        checks++;
        if (rec_wr[1] !== 1'b0 || rec_ax[1] !== 1 || rec_ax[2] !== 1 || rec_srdy[2] !== 1'b1) begin
            failures++;
            $display("FAIL gap_hold: wr1=%b ax1=%0d ax2=%0d srdy2=%b expected 0/1/1/1",
                     rec_wr[1], rec_ax[1], rec_ax[2], rec_srdy[2]);
        end
        checks++;
        if (rec_aw[5] !== 0 || rec_busy[5] !== 1'b1 || rec_clr[5 + LAT] !== 1'b1 || rec_busy[35] !== 1'b0) begin
            failures++;
            $display("FAIL gap_issue: aw5=%0d busy5=%b clr=%b busy_end=%b expected 0/1/1/0",
                     rec_aw[5], rec_busy[5], rec_clr[5 + LAT], rec_busy[35]);
        end
    endtask

    task automatic test_reset_mid();
        int n_hs;
        run(5, 48'h7, '1);
        checks++;
        if (rec_aw[4] !== 1 || rec_busy[4] !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre: aw=%0d busy=%b expected 1/1", rec_aw[4], rec_busy[4]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs_vec !== 15'd0) begin
            failures++;
            $display("FAIL mid_reset_outs: got %b expected all zero", outs_vec);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(30, 48'h7, '1);
        checks++;
        if (rec_aw[3] !== 0 || rec_ab[3] !== 0 || rec_clr[3 + LAT] !== 1'b1) begin
            failures++;
            $display("FAIL mid_fresh_issue: aw=%0d ab=%0d clr=%b expected 0/0/1", rec_aw[3], rec_ab[3], rec_clr[3 + LAT]);
        end
        n_hs = 0;
        for (int c = 0; c < 30; c++) begin
            if (rec_hs[c] === 1'b1) n_hs++;
        end
        checks++;
        if (rec_ol[3 + N + LAT] !== 1'b1 || n_hs !== M) begin
            failures++;
            $display("FAIL mid_fresh_rows: ol=%b hs=%0d expected 1/%0d", rec_ol[3 + N + LAT], n_hs, M);
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        test_reset();
        test_nominal();
        test_row_period();
        test_backpressure();
        test_s_gaps();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
